tsp_ctrl_input: RTL and testbench

//  Control front-end feeding the 8-LED pattern core (TSP_PST_TTR_TNV).

---
 rtl/tsp_ctrl_input.sv | 91 +++++++++
 tb/tb_tsp_ctrl_input.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tsp_ctrl_input.sv
// Button front-end for the 8-LED pattern core: synchronizes and debounces the run/stop
// and mode buttons, turns presses into ss/mode levels, and prescales the step tick.
module tsp_ctrl_input #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TICK_DIV        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_mode,
    output logic       ss,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    // Bit 0 carries the run/stop button, bit 1 the mode button.
    logic [1:0]            w_raw;
    logic [1:0]            r_meta;
    logic [1:0]            r_sync;
    logic [1:0]            r_stable;
    logic [1:0]            r_stable_d;
    logic [1:0]            r_press;
    logic [1:0][DB_W-1:0]  r_db_cnt;

    logic                  r_ss;
    logic [1:0]            r_mode;
    logic                  r_tick;
    logic [TK_W-1:0]       r_pre_cnt;

    assign w_raw = {btn_mode, btn_ss};
    assign ss    = r_ss;
    assign mode  = r_mode;
    assign tick  = r_tick;

    // Any bounce back to the stable level restarts the count from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta     <= '0;
            r_sync     <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            r_press    <= '0;
            r_db_cnt   <= '0;
        end else begin
            r_meta     <= w_raw;
            r_sync     <= r_meta;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press on either button restarts the step period so the new state gets a full step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ss      <= 1'b0;
            r_mode    <= 2'd0;
            r_tick    <= 1'b0;
            r_pre_cnt <= '0;
        end else begin
            if (r_press[0]) r_ss <= ~r_ss;
            if (r_press[1]) r_mode <= r_mode + 2'd1;

            if (!r_ss || r_press[0] || r_press[1]) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b0;
            end else if (r_pre_cnt == TK_LAST) begin
                r_pre_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
                r_tick    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tsp_ctrl_input.sv
// Directed bench for tsp_ctrl_input with DEBOUNCE_CYCLES=20 and TICK_DIV=8.
module tb_tsp_ctrl_input;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_mode = 1'b0;
  logic       ss;
  logic [1:0] mode;
  logic       tick;

  int checks = 0;
  int passed = 0;

  tsp_ctrl_input #(.DEBOUNCE_CYCLES(20), .TICK_DIV(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_ss   (btn_ss),
    .btn_mode (btn_mode),
    .ss       (ss),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_mode_press();
    btn_mode = 1'b1;
    cyc(30);
    btn_mode = 1'b0;
    cyc(30);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ss !== 1'b0 || mode !== 2'd0 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_hold: %0d bad cycles, want 0", bad);
    else passed++;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      if (ss !== 1'b0 || mode !== 2'd0 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_idle: %0d bad cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int r = 0; r < 4; r++) begin
      btn_ss = 1'b1;
      for (int k = 0; k < 5; k++) begin
        cyc(1);
        if (ss !== 1'b0 || tick !== 1'b0) bad++;
      end
      btn_ss = 1'b0;
      for (int k = 0; k < 5; k++) begin
        cyc(1);
        if (ss !== 1'b0 || tick !== 1'b0) bad++;
      end
    end
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (ss !== 1'b0 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL bounce_reject: %0d bad cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_ss_clean();
    logic exp_tick;
    btn_ss = 1'b1;
    cyc(23);
    checks++;
    if (ss !== 1'b0) $display("FAIL ss_edge22: got %b want 0", ss);
    else passed++;
    cyc(1);
    checks++;
    if (ss !== 1'b1) $display("FAIL ss_edge23: got %b want 1", ss);
    else passed++;
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (k == 7) btn_ss = 1'b0;
      exp_tick = (k % 8 == 0);
      checks++;
      if (tick !== exp_tick) $display("FAIL ss_tick_k%0d: got %b want %b", k, tick, exp_tick);
      else passed++;
    end
    cyc(40);
    checks++;
    if (ss !== 1'b1) $display("FAIL ss_release_no_event: got %b want 1", ss);
    else passed++;
  endtask

  task automatic test_mode();
    logic [1:0] prev;
    logic [1:0] exp_mode;
    logic       exp_tick;
    prev = 2'd0;
    for (int p = 1; p <= 4; p++) begin
      exp_mode = 2'(p % 4);
      btn_mode = 1'b1;
      cyc(23);
      checks++;
      if (mode !== prev) $display("FAIL mode_pre_p%0d: got %0d want %0d", p, mode, prev);
      else passed++;
      cyc(1);
      checks++;
      if (mode !== exp_mode) $display("FAIL mode_p%0d: got %0d want %0d", p, mode, exp_mode);
      else passed++;
      for (int k = 1; k <= 8; k++) begin
        cyc(1);
        if (k == 7) btn_mode = 1'b0;
        exp_tick = (k == 8);
        checks++;
        if (tick !== exp_tick) $display("FAIL mode_phase_p%0d_k%0d: got %b want %b", p, k, tick, exp_tick);
        else passed++;
      end
      cyc(30);
      prev = exp_mode;
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    drive_mode_press();
    drive_mode_press();
    checks++;
    if (mode !== 2'd2 || ss !== 1'b1) $display("FAIL mid_setup: got ss=%b mode=%0d want ss=1 mode=2", ss, mode);
    else passed++;
    cyc(3);
    btn_ss = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ss !== 1'b0) $display("FAIL mid_async_ss: got %b want 0", ss);
    else passed++;
    checks++;
    if (mode !== 2'd0) $display("FAIL mid_async_mode: got %0d want 0", mode);
    else passed++;
    checks++;
    if (tick !== 1'b0) $display("FAIL mid_async_tick: got %b want 0", tick);
    else passed++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (ss !== 1'b0 || mode !== 2'd0 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL mid_reset_hold: %0d bad cycles, want 0", bad);
    else passed++;
    reset = 1'b0;
    cyc(23);
    checks++;
    if (ss !== 1'b0) $display("FAIL mid_rel_edge22: got %b want 0", ss);
    else passed++;
    cyc(1);
    checks++;
    if (ss !== 1'b1) $display("FAIL mid_rel_edge23: got %b want 1", ss);
    else passed++;
    btn_ss = 1'b0;
    cyc(40);
  endtask

  task automatic test_simultaneous();
    int bad;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    btn_ss = 1'b1;
    btn_mode = 1'b1;
    cyc(23);
    checks++;
    if (ss !== 1'b0 || mode !== 2'd0) $display("FAIL sim_edge22: got ss=%b mode=%0d want ss=0 mode=0", ss, mode);
    else passed++;
    cyc(1);
    checks++;
    if (ss !== 1'b1) $display("FAIL sim_ss: got %b want 1", ss);
    else passed++;
    checks++;
    if (mode !== 2'd1) $display("FAIL sim_mode: got %0d want 1", mode);
    else passed++;
    cyc(6);
    btn_ss = 1'b0;
    btn_mode = 1'b0;
    cyc(30);
    btn_ss = 1'b1;
    cyc(23);
    checks++;
    if (ss !== 1'b1) $display("FAIL stop_edge22: got %b want 1", ss);
    else passed++;
    cyc(1);
    checks++;
    if (ss !== 1'b0) $display("FAIL stop_ss: got %b want 0", ss);
    else passed++;
    checks++;
    if (tick !== 1'b0) $display("FAIL stop_tick: got %b want 0", tick);
    else passed++;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (tick !== 1'b0 || ss !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL stop_no_tick: %0d bad cycles, want 0", bad);
    else passed++;
    checks++;
    if (mode !== 2'd1) $display("FAIL stop_mode_kept: got %0d want 1", mode);
    else passed++;
    btn_ss = 1'b0;
    cyc(30);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_ss_clean();
    test_mode();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
